// File: rtl/timer_bus_initiator.sv
// Command-driven Avalon-MM initiator for a simple interval-timer slave.
// Converts START/STOP/SNAP/ACK commands into fixed single-cycle register access sequences.
module timer_bus_initiator #(
    parameter bit AUTO_ACK = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_period,
    input  logic        cmd_cont,
    input  logic        cmd_ito,
    output logic        rsp_valid,
    output logic [1:0]  rsp_op,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    input  logic        irq
);

    localparam logic [1:0] OpStart = 2'd0;
    localparam logic [1:0] OpStop  = 2'd1;
    localparam logic [1:0] OpSnap  = 2'd2;
    localparam logic [1:0] OpAck   = 2'd3;

    localparam logic [2:0] AddrStatus  = 3'd0;
    localparam logic [2:0] AddrControl = 3'd1;
    localparam logic [2:0] AddrPeriodL = 3'd2;
    localparam logic [2:0] AddrPeriodH = 3'd3;
    localparam logic [2:0] AddrSnapL   = 3'd4;
    localparam logic [2:0] AddrSnapH   = 3'd5;

    typedef enum logic [3:0] {
        StIdle,
        StWrPl,
        StWrPh,
        StWrCtl,
        StWrStop,
        StWrSnap,
        StRdSl,
        StRdSh,
        StCapSh,
        StRdSt,
        StWrSt,
        StResp
    } state_t;

    state_t      r_state;
    state_t      w_state_d;
    logic [1:0]  r_op;
    logic [31:0] r_period;
    logic        r_cont_sh;
    logic        r_ito_sh;
    logic [15:0] r_snap_lo;
    logic [1:0]  r_rsp_op;
    logic [31:0] r_rsp_data;
    logic [1:0]  r_rsp_status;

    logic        w_accept;
    logic        w_auto_ack;
    logic        w_rsp_load;

    assign w_accept   = (r_state == StIdle) && cmd_valid;
    // A real command always takes precedence over the self-initiated acknowledge.
    assign w_auto_ack = AUTO_ACK && (r_state == StIdle) && !cmd_valid && irq;
    assign w_rsp_load = (r_state == StWrCtl) || (r_state == StWrStop) ||
                        (r_state == StCapSh) || (r_state == StWrSt);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        OpStart: w_state_d = StWrPl;
                        OpStop:  w_state_d = StWrStop;
                        OpSnap:  w_state_d = StWrSnap;
                        OpAck:   w_state_d = StRdSt;
                        default: w_state_d = StIdle;
                    endcase
                end else if (w_auto_ack) begin
                    w_state_d = StRdSt;
                end
            end
            StWrPl:   w_state_d = StWrPh;
            StWrPh:   w_state_d = StWrCtl;
            StWrCtl:  w_state_d = StResp;
            StWrStop: w_state_d = StResp;
            StWrSnap: w_state_d = StRdSl;
            StRdSl:   w_state_d = StRdSh;
            StRdSh:   w_state_d = StCapSh;
            StCapSh:  w_state_d = StResp;
            StRdSt:   w_state_d = StWrSt;
            StWrSt:   w_state_d = StResp;
            StResp:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Bus outputs are decoded from the registered state only, so every access lasts one cycle.
    always_comb begin
        av_chipselect = 1'b0;
        av_write_n    = 1'b1;
        av_address    = 3'd0;
        av_writedata  = 16'd0;
        unique case (r_state)
            StWrPl: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = AddrPeriodL;
                av_writedata  = r_period[15:0];
            end
            StWrPh: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = AddrPeriodH;
                av_writedata  = r_period[31:16];
            end
            StWrCtl: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = AddrControl;
                av_writedata  = {12'd0, 2'b01, r_cont_sh, r_ito_sh};
            end
            StWrStop: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = AddrControl;
                av_writedata  = {12'd0, 2'b10, r_cont_sh, r_ito_sh};
            end
            StWrSnap: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = AddrSnapL;
            end
            StRdSl: begin
                av_chipselect = 1'b1;
                av_address    = AddrSnapL;
            end
            StRdSh: begin
                av_chipselect = 1'b1;
                av_address    = AddrSnapH;
            end
            StRdSt: begin
                av_chipselect = 1'b1;
                av_address    = AddrStatus;
            end
            StWrSt: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = AddrStatus;
            end
            default: begin
                av_chipselect = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_op         <= 2'd0;
            r_period     <= 32'd0;
            r_cont_sh    <= 1'b0;
            r_ito_sh     <= 1'b0;
            r_snap_lo    <= 16'd0;
            r_rsp_op     <= 2'd0;
            r_rsp_data   <= 32'd0;
            r_rsp_status <= 2'd0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_op <= cmd_op;
                if (cmd_op == OpStart) begin
                    r_period  <= cmd_period;
                    r_cont_sh <= cmd_cont;
                    r_ito_sh  <= cmd_ito;
                end
            end else if (w_auto_ack) begin
                r_op <= OpAck;
            end
            // Read data arrives one cycle after each read access.
            if (r_state == StRdSh) begin
                r_snap_lo <= av_readdata;
            end
            if (w_rsp_load) begin
                r_rsp_op     <= r_op;
                r_rsp_data   <= (r_state == StCapSh) ? {av_readdata, r_snap_lo} : 32'd0;
                r_rsp_status <= (r_state == StWrSt) ? av_readdata[1:0] : 2'd0;
            end
        end
    end

    assign cmd_ready  = (r_state == StIdle);
    assign rsp_valid  = (r_state == StResp);
    assign rsp_op     = r_rsp_op;
    assign rsp_data   = r_rsp_data;
    assign rsp_status = r_rsp_status;

endmodule

// File: doc/timer_bus_initiator.md
TIMER_BUS_INITIATOR -- requirements
Module: timer_bus_initiator

Interface
REQ-001 SHALL have parameter: AUTO_ACK, 0, when 1 the block acknowledges a pending timer irq on its own while idle.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port: clk  in  1  rising-edge clock.
REQ-004 SHALL have port: reset  in  1  synchronous active-high reset.
REQ-005 SHALL have port: cmd_valid  in  1  command request.
REQ-006 SHALL have port: cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready.
REQ-007 SHALL have port: cmd_op  in  2  0=START, 1=STOP, 2=SNAP, 3=ACK.
REQ-008 SHALL have port: cmd_period  in  32  START period value.
REQ-009 SHALL have port: cmd_cont  in  1  START continuous-mode bit.
REQ-010 SHALL have port: cmd_ito  in  1  START interrupt-enable bit.
REQ-011 SHALL have port: rsp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: rsp_op  out  2  op that completed.
REQ-013 SHALL have port: rsp_data  out  32  SNAP counter value, else 0.
REQ-014 SHALL have port: rsp_status  out  2  ACK status {running,timeout}, else 0.
REQ-015 SHALL have ports: av_address out 3, av_chipselect out 1, av_write_n out 1, av_writedata out 16 (timer slave register map: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h).
REQ-016 SHALL have ports: av_readdata in 16 (registered, fixed read latency 1, no waitrequest); irq in 1 (timer interrupt).

Function
REQ-017 SHALL accept a command only in IDLE; cmd_ready = (state==IDLE); first bus cycle occurs on the cycle after acceptance.
REQ-018 SHALL drive bus idle values in every non-access cycle: chipselect 0, write_n 1, address 0, writedata 0.
REQ-019 SHALL perform each access in exactly one cycle: write = chipselect 1, write_n 0; read = chipselect 1, write_n 1, data sampled from av_readdata on the following cycle.
REQ-020 START SHALL issue writes: addr 2 = cmd_period[15:0], addr 3 = cmd_period[31:16], addr 1 = {0,1,cmd_cont,cmd_ito} in bits [3:0], upper bits 0; control write last so the start bit overrides the period-write forced stop.
REQ-021 START SHALL latch cmd_cont and cmd_ito into internal shadow bits (reset 0).
REQ-022 STOP SHALL write addr 1 = {1,0,cont_shadow,ito_shadow}.
REQ-023 SNAP SHALL: cycle1 write addr 4 (data 0); cycle2 read addr 4; cycle3 read addr 5 and capture low half; cycle4 capture high half; rsp_data = {high,low}.
REQ-024 ACK SHALL: cycle1 read addr 0; cycle2 capture av_readdata[1:0] into rsp_status and write addr 0 (data 0) to clear timeout.
REQ-025 SHALL assert rsp_valid for one cycle on the cycle after the last bus access (START cycle 4, STOP cycle 2, SNAP cycle 5, ACK cycle 3), return to IDLE on the same edge; cmd_ready high the next cycle.
REQ-026 rsp_data/rsp_status/rsp_op SHALL hold their values until the next rsp_valid.
REQ-027 States: IDLE, WR_PL, WR_PH, WR_CTL, WR_STOP, WR_SNAP, RD_SL, RD_SH, CAP_SH, RD_ST, WR_ST, RESP.
REQ-028 If AUTO_ACK=1 and irq=1 in IDLE with cmd_valid=0, SHALL run the ACK sequence internally (cmd_ready 0 meanwhile) and report rsp_op=3.
REQ-029 cmd_valid SHALL win over AUTO_ACK when both occur in the same IDLE cycle; irq is ignored outside IDLE.
REQ-030 cmd_* inputs SHALL be sampled only at acceptance; changes while busy have no effect.

Reset
REQ-031 On reset SHALL enter IDLE; cmd_ready 1 on the first cycle after reset deasserts; rsp_valid 0, rsp_op 0, rsp_data 0, rsp_status 0, shadow bits 0, bus at idle values.
REQ-032 Reset mid-sequence SHALL abandon the sequence with no further bus access and no rsp_valid.

Verification
REQ-033 START period 0x0001_86A0, cont 1, ito 1 -> writes (2,0x86A0),(3,0x0001),(1,0x0007) on consecutive cycles, rsp_valid cycle 4, timer slave running.
REQ-034 SNAP with slave counter held at 0x0012_3456 -> write addr 4, reads 4 then 5, rsp_data 0x0012_3456 on cycle 5.
REQ-035 ACK after timeout with counter running -> rsp_status 2'b11, addr 0 write follows, slave irq deasserts.
REQ-036 AUTO_ACK=1, irq and cmd_valid(STOP) same cycle -> STOP (addr 1 = 0x000B after START cont 1, ito 1) first, then auto ACK, rsp_op 1 then 3.
REQ-037 Reset asserted during SNAP cycle 3 -> bus idle next cycle, no rsp_valid, cmd_ready 1 after release.
